fifo_sync_prog: RTL
===================

# fifo_sync_prog

Parametrised synchronous FIFO that succeeds the fixed 16x8 FIFO. It adds an occupancy count, runtime-programmable almost-full and almost-empty thresholds, a synchronous flush and a high-water mark. Simultaneous read and write while full is allowed. It sits between any single-clock producer and consumer in the datapath, and the UVM environment exercises it through its interface.

## Interface
- FIFO_WIDTH, 16, data word width (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, any integer; need not be a power of 2)
- CNT_W, $clog2(FIFO_DEPTH+1), derived width of the count and threshold signals; not overridden

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- flush  in  1  synchronous clear; highest priority
- af_thresh  in  CNT_W  almostfull threshold
- ae_thresh  in  CNT_W  almostempty threshold
- data_out  out  FIFO_WIDTH  read data
- wr_ack  out  1  previous-cycle write accepted
- overflow  out  1  previous-cycle write rejected
- underflow  out  1  previous-cycle read rejected
- full, empty, almostfull, almostempty  out  1  occupancy flags
- count  out  CNT_W  current occupancy
- high_water  out  CNT_W  maximum count since reset or flush

## Operation
- Write is accepted when wr_en && (!full || rd accepted same cycle). Read is accepted when rd_en && !empty.
- Full with wr_en && rd_en: both are accepted. count is unchanged, overflow=0.
- Empty with wr_en && rd_en: only the write is accepted, and underflow=1.
- Full with wr_en && !rd_en: the write is dropped, memory is untouched, and overflow=1.
- Pointers wrap from FIFO_DEPTH-1 to 0 explicitly; there is no power-of-2 assumption.
- Flag decode from the count register:
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - almostfull = (count >= af_thresh)
  - almostempty = (count <= ae_thresh)
- Thresholds are sampled live. af_thresh=0 gives almostfull always 1. af_thresh > FIFO_DEPTH gives almostfull never 1.
- high_water is updated to the next count when the next count exceeds it. It saturates at FIFO_DEPTH.
- flush=1 has these effects on the next edge:
  - pointers, count and high_water go to 0
  - wr_ack, overflow and underflow are 0
  - data_out holds
  - wr_en and rd_en are ignored that cycle
- Reset values: data_out 0, wr_ack 0, overflow 0, underflow 0, count 0, high_water 0, full 0, empty 1, almostempty 1, almostfull = (af_thresh==0).
- Reset asserted mid-operation discards all contents immediately. Memory contents are not cleared and are never observable.

## Timing
- wr_ack, overflow and underflow are registered and pulse for exactly one cycle, in the cycle after the request.
- count and the flags reflect all accepted operations on the edge after the request. A write into an empty FIFO clears empty 1 cycle later.
- Standard mode: data_out is registered and updates 1 cycle after an accepted read. It holds otherwise, including on a rejected read.
- Back-to-back reads are supported at 1 word per cycle, and likewise writes.
- A write is readable in the cycle after it is accepted: rd_en may be asserted on the first cycle empty=0.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out continuously presents the head entry whenever empty=0, and is undefined-but-stable (last value) when empty.
  - rd_en pops the head, and the next entry appears on data_out on the following edge.
  - Read latency is 0 cycles from head availability.
- FIFO_FWFT_EN undefined: standard registered-read mode as above.
- All flag, count, ack and error behaviour is identical in both modes.

## Structure
- Package fifo_pkg holds:
  - a width helper function for CNT_W
  - a localparam for the default FIFO_WIDTH and FIFO_DEPTH
  - the typedef for the count type, used by the RTL and by the scoreboard
- Sub-module fifo_mem is a simple dual-port register array: one write port, one read port with a combinational read address. The FWFT and registered-output choice is made in the top module.
- The top module holds the pointers, count, flags, response registers and high_water.
- The existing FIFO interface gains flush, af_thresh, ae_thresh, count and high_water signals, plus a parameterised CNT_W.

## Test plan
- Fill test, DEPTH=8, af_thresh=6, ae_thresh=1, 8 writes of 0x0001..0x0008: almostfull rises after the 6th write, full after the 8th, count=8, high_water=8. A 9th write gives overflow=1 for one cycle and count stays 8.
- Drain test: 8 reads from full return 0x0001..0x0008 in order; empty after the last. A 9th read gives underflow=1 and data_out holds 0x0008 (standard mode).
- Simultaneous access:
  - full with wr+rd of 0x00AA: count stays 8, wr_ack=1, overflow=0, and 0x00AA is read 8th later
  - empty with wr+rd: underflow=1, count=1
- Wrap-around, DEPTH=5: 1000 random wr/rd cycles matched against a reference queue. Every value and every flag matches cycle-exactly.
- Flush with count=4: next cycle count=0, empty=1, high_water=0, data_out unchanged. A concurrent wr_en is ignored.
- Reset mid-burst with rst_n low asynchronously: all outputs take their reset values before the next clk edge. A write after release is read back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, width helper and count type for the fifo_sync_prog FIFO family.
package fifo_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 8;

    // Width able to hold every occupancy value 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DefaultCntW = cnt_width(DefaultDepth);

    typedef logic [DefaultCntW-1:0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one combinational read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: contents are only observable after being written.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with occupancy count, live thresholds, flush and high-water mark.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is a registered read.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DefaultWidth,
    parameter int unsigned FIFO_DEPTH = DefaultDepth,
    parameter int unsigned CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      high_water
);

    localparam int unsigned            PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]       LastPtr  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]       DepthCnt = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count, r_high_water;
    logic                  r_wr_ack, r_overflow, r_underflow;
    logic [FIFO_WIDTH-1:0] r_data_out;

    logic [PTR_W-1:0]      w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [CNT_W-1:0]      w_count_nxt, w_high_water_nxt;
    logic                  w_wr_acc, w_rd_acc, w_full, w_empty;
    logic [FIFO_WIDTH-1:0] w_rd_data;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == DepthCnt);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_rd_acc         = rd_en && !w_empty && !flush;
        w_wr_acc         = wr_en && (!w_full || w_rd_acc) && !flush;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_high_water_nxt = r_high_water;
        if (flush) begin
            w_wr_ptr_nxt     = '0;
            w_rd_ptr_nxt     = '0;
            w_count_nxt      = '0;
            w_high_water_nxt = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            if (w_rd_acc) w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
            // Count never exceeds FIFO_DEPTH, so this saturates on its own.
            if (w_count_nxt > r_high_water) w_high_water_nxt = w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_high_water <= '0;
            r_wr_ack     <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_high_water <= w_high_water_nxt;
            r_wr_ack     <= w_wr_acc;
            r_overflow   <= wr_en && !flush && !w_wr_acc;
            r_underflow  <= rd_en && !flush && !w_rd_acc;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

`ifdef FIFO_FWFT_EN
    // Track the presented head so the output stays stable once the FIFO empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (!w_empty) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = w_empty ? r_data_out : w_rd_data;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = r_data_out;
`endif

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= af_thresh);
    assign almostempty = (r_count <= ae_thresh);
    assign count       = r_count;
    assign high_water  = r_high_water;

endmodule
